// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared FPU opcodes, sequencer state encoding, command record
//                and opcode classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Opcode encodings understood by the FPU
    localparam logic [5:0] c_op_fneg = 6'd0;
    localparam logic [5:0] c_op_fadd = 6'd1;
    localparam logic [5:0] c_op_fsub = 6'd2;
    localparam logic [5:0] c_op_fmul = 6'd3;
    localparam logic [5:0] c_op_fclt = 6'd4;
    localparam logic [5:0] c_op_ftoi = 6'd5;
    localparam logic [5:0] c_op_itof = 6'd6;
    localparam logic [5:0] c_op_mov  = 6'd7;
    localparam logic [5:0] c_op_set  = 6'd8;
    localparam logic [5:0] c_op_get  = 6'd9;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } fpu_state_t;

    // One queued FPU command
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  x1;
        logic [4:0]  x2;
        logic [4:0]  y;
        logic [31:0] data;
    } fpu_cmd_t;

    localparam int c_cmd_w = $bits(fpu_cmd_t);

    // True for every opcode the FPU implements
    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            c_op_fneg, c_op_fadd, c_op_fsub, c_op_fmul, c_op_fclt,
            c_op_ftoi, c_op_itof, c_op_mov, c_op_set, c_op_get:
                is_known_op = 1'b1;
            default:
                is_known_op = 1'b0;
        endcase
    endfunction

    // True for opcodes whose result goes back to the integer side
    function automatic logic has_result(input logic [5:0] op);
        has_result = (op == c_op_fclt) || (op == c_op_ftoi) || (op == c_op_get);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_req_fifo
//  Description : In-order command queue for the FPU sequencer. The ready flag
//                is registered from the next occupancy, so it never reacts
//                combinationally to a same-cycle pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_push,
    input  logic [c_cmd_w-1:0] i_cmd,
    input  logic               i_pop,
    output logic [c_cmd_w-1:0] o_head,
    output logic               o_empty,
    output logic               o_ready
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

    logic [c_cmd_w-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_aw:0]      r_count;
    logic               r_ready;

    logic               w_push;
    logic               w_pop;
    logic [c_aw:0]      w_count_nxt;

    assign w_push  = i_push && r_ready;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;

    // Occupancy after this cycle; push and pop together cancel out
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Pointers (wrap naturally since DEPTH is a power of two), count, ready
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_full);
        end
    end

    // Payload storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cmd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_seq
//  Description : Queues FPU commands and issues them one at a time, holding
//                each on the FPU port until completion, inserting a writeback
//                gap after multi-cycle ops and returning integer-side results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [4:0]  req_x1,
    input  logic [4:0]  req_x2,
    input  logic [4:0]  req_y,
    input  logic [31:0] req_data,
    output logic        fpu_ready,
    output logic [5:0]  fpu_operation,
    output logic [4:0]  fpu_x1,
    output logic [4:0]  fpu_x2,
    output logic [4:0]  fpu_y,
    output logic [31:0] fpu_in_data,
    input  logic        fpu_valid,
    input  logic        fpu_out_data1,
    input  logic [31:0] fpu_out_data32,
    output logic        rsp_valid,
    output logic        rsp_data1,
    output logic [31:0] rsp_data32,
    output logic        bad_op,
    output logic        busy
);

    fpu_state_t  r_state;
    logic        r_fpu_ready;
    logic        r_rsp_valid;
    logic        r_rsp_data1;
    logic [31:0] r_rsp_data32;
    logic        r_bad_op;

    fpu_cmd_t           w_req_cmd;
    fpu_cmd_t           w_head;
    logic [c_cmd_w-1:0] w_head_bits;
    logic               w_empty;
    logic               w_done;
    logic               w_drop;
    logic               w_pop;

    assign w_req_cmd = '{op: req_op, x1: req_x1, x2: req_x2, y: req_y, data: req_data};
    assign w_head    = w_head_bits;

    // Completion only counts while a command is actually on the FPU port
    assign w_done = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && fpu_valid;
    // Unknown opcodes are dropped from the head without ever being issued
    assign w_drop = (r_state == ST_IDLE) && !w_empty && !is_known_op(w_head.op);
    assign w_pop  = w_done || w_drop;

    fpu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (req_valid),
        .i_cmd   (w_req_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head_bits),
        .o_empty (w_empty),
        .o_ready (req_ready)
    );

    // Issue FSM with registered handshake, response capture and bad-op pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_fpu_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data1  <= 1'b0;
            r_rsp_data32 <= '0;
            r_bad_op     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_bad_op    <= w_drop;
            if (w_done && has_result(w_head.op)) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_data1  <= fpu_out_data1;
                r_rsp_data32 <= fpu_out_data32;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && is_known_op(w_head.op)) begin
                        r_state     <= ST_ISSUE;
                        r_fpu_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Single-cycle ops finish here and need no writeback gap
                    if (fpu_valid) begin
                        r_state     <= ST_IDLE;
                        r_fpu_ready <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fpu_valid) begin
                        r_state     <= ST_GAP;
                        r_fpu_ready <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_fpu_ready <= 1'b0;
                end
            endcase
        end
    end

    assign fpu_ready     = r_fpu_ready;
    assign fpu_operation = w_head.op;
    assign fpu_x1        = w_head.x1;
    assign fpu_x2        = w_head.x2;
    assign fpu_y         = w_head.y;
    assign fpu_in_data   = w_head.data;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data1     = r_rsp_data1;
    assign rsp_data32    = r_rsp_data32;
    assign bad_op        = r_bad_op;
    assign busy          = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire
